fde_controller: RTL and testbench

- Control sequencer for the 8-bit fetch-decode-execute CPU. Owns the program counter (PC) and instruction register (IR).
- Steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK, and drives the ALU, accumulator and register-file write controls of the existing datapath.
- Sits inside the CPU top, between instruction memory and the datapath. Honours i_stop at instruction boundaries.

---
 rtl/fde_pkg.sv | 32 +++
 rtl/fde_decoder.sv | 40 ++++
 rtl/fde_controller.sv | 132 +++++++++++++
 tb/tb_fde_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fde_pkg.sv
// Shared encodings for the fetch-decode-execute controller: FSM states,
// instruction opcodes and ALU operation selects.
package fde_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_LDI  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;

endpackage

// File: rtl/fde_decoder.sv
// Combinational opcode decoder: maps the IR opcode nibble to the control
// requests the sequencer qualifies with its current state.
module fde_decoder
    import fde_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [2:0] alu_op_o,
    output logic       acc_we_req_o,
    output logic       st_o,
    output logic       jmp_o,
    output logic       jz_o,
    output logic       halt_o,
    output logic       illegal_o
);

    // Opcodes 9..E fall to the default arm: flagged illegal, otherwise a NOP.
    always_comb begin
        alu_op_o     = ALU_PASS;
        acc_we_req_o = 1'b0;
        st_o         = 1'b0;
        jmp_o        = 1'b0;
        jz_o         = 1'b0;
        halt_o       = 1'b0;
        illegal_o    = 1'b0;
        case (opcode_i)
            OP_NOP:  ;
            OP_LDI:  begin alu_op_o = ALU_LDI; acc_we_req_o = 1'b1; end
            OP_ADD:  begin alu_op_o = ALU_ADD; acc_we_req_o = 1'b1; end
            OP_SUB:  begin alu_op_o = ALU_SUB; acc_we_req_o = 1'b1; end
            OP_AND:  begin alu_op_o = ALU_AND; acc_we_req_o = 1'b1; end
            OP_OR:   begin alu_op_o = ALU_OR;  acc_we_req_o = 1'b1; end
            OP_ST:   st_o   = 1'b1;
            OP_JMP:  jmp_o  = 1'b1;
            OP_JZ:   jz_o   = 1'b1;
            OP_HALT: halt_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fde_controller.sv
// Fetch-decode-execute sequencer: owns PC, IR and the retire counter and
// drives datapath strobes as Moore functions of state and IR.
module fde_controller
    import fde_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int INSTR_W  = 8,
    parameter int RETIRE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stop,
    input  logic [INSTR_W-1:0]  i_imem_data,
    input  logic                i_zero,
    output logic [ADDR_W-1:0]   o_imem_addr,
    output logic [2:0]          o_alu_op,
    output logic                o_acc_we,
    output logic [3:0]          o_imm,
    output logic                o_write_en,
    output logic [3:0]          o_write_add,
    output logic [2:0]          o_state,
    output logic                o_halted,
    output logic                o_illegal,
    output logic [RETIRE_W-1:0] o_retired
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                zero_q, zero_d;

    logic [2:0] dec_alu_op;
    logic       dec_acc_we_req;
    logic       dec_st;
    logic       dec_jmp;
    logic       dec_jz;
    logic       dec_halt;
    logic       dec_illegal;

    fde_decoder u_decoder (
        .opcode_i     (ir_q[INSTR_W-1 -: 4]),
        .alu_op_o     (dec_alu_op),
        .acc_we_req_o (dec_acc_we_req),
        .st_o         (dec_st),
        .jmp_o        (dec_jmp),
        .jz_o         (dec_jz),
        .halt_o       (dec_halt),
        .illegal_o    (dec_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            zero_q    <= zero_d;
        end
    end

    // i_stop is only looked at in IDLE and WRITEBACK, i.e. instruction boundaries.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        zero_d    = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (!i_stop) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = i_imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = dec_halt ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                zero_d  = i_zero;
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (dec_jmp || (dec_jz && zero_q)) pc_d = ADDR_W'(ir_q[3:0]);
                else                               pc_d = pc_q + ADDR_W'(1);
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = i_stop ? ST_IDLE : ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are forced low while reset is asserted so a reset landing in
    // WRITEBACK aborts the register-file write.
    always_comb begin
        o_alu_op    = ALU_PASS;
        o_acc_we    = 1'b0;
        o_write_en  = 1'b0;
        o_write_add = 4'd0;
        o_illegal   = 1'b0;
        if (!i_reset) begin
            if (state_q == ST_EXECUTE && dec_acc_we_req) begin
                o_alu_op = dec_alu_op;
                o_acc_we = 1'b1;
            end
            if (state_q == ST_WRITEBACK && dec_st) begin
                o_write_en  = 1'b1;
                o_write_add = ir_q[3:0];
            end
            if (state_q == ST_DECODE) o_illegal = dec_illegal;
        end
    end

    assign o_imem_addr = pc_q;
    assign o_imm       = ir_q[3:0];
    assign o_state     = state_q;
    assign o_halted    = (state_q == ST_HALT);
    assign o_retired   = retired_q;

endmodule

// File: tb/tb_fde_controller.sv
// Self-checking bench for fde_controller: directed table, hand-written
// corner sequences and random programs against a cycle-level reference model.
module tb_fde_controller;

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_FETCH = 3'd1;
    localparam logic [2:0] P_DECODE = 3'd2;
    localparam logic [2:0] P_EXEC = 3'd3;
    localparam logic [2:0] P_WB = 3'd4;
    localparam logic [2:0] P_HALT = 3'd5;

    logic       clk = 1'b0;
    logic       rst, stopIn, zeroIn;
    logic [7:0] imemData;
    logic [3:0] imemAddr;
    logic [2:0] aluOp;
    logic       accWe;
    logic [3:0] imm;
    logic       writeEn;
    logic [3:0] writeAdd;
    logic [2:0] stateOut;
    logic       halted;
    logic       illegal;
    logic [7:0] retired;

    logic [7:0] mem [16];

    int total = 0;
    int bad = 0;

    logic [2:0] mPhase;
    logic [3:0] mPc;
    logic [7:0] mIr;
    logic [7:0] mRet;
    logic       mZero;

    always #5 clk = ~clk;

    assign imemData = mem[imemAddr];

    fde_controller dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_stop      (stopIn),
        .i_imem_data (imemData),
        .i_zero      (zeroIn),
        .o_imem_addr (imemAddr),
        .o_alu_op    (aluOp),
        .o_acc_we    (accWe),
        .o_imm       (imm),
        .o_write_en  (writeEn),
        .o_write_add (writeAdd),
        .o_state     (stateOut),
        .o_halted    (halted),
        .o_illegal   (illegal),
        .o_retired   (retired)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic z);
        rst    = r;
        stopIn = s;
        zeroIn = z;
    endtask

    // Reference model: one instruction = fetch, decode, execute, writeback.
    task automatic advanceModel();
        logic [3:0] op;
        op = mIr[7:4];
        if (rst) begin
            mPhase = P_IDLE; mPc = 4'd0; mIr = 8'd0; mRet = 8'd0; mZero = 1'b0;
        end else begin
            case (mPhase)
                P_IDLE:   if (!stopIn) mPhase = P_FETCH;
                P_FETCH:  begin mIr = mem[mPc]; mPhase = P_DECODE; end
                P_DECODE: mPhase = (op == 4'hF) ? P_HALT : P_EXEC;
                P_EXEC:   begin mZero = zeroIn; mPhase = P_WB; end
                P_WB: begin
                    if (op == 4'h7 || (op == 4'h8 && mZero)) mPc = mIr[3:0];
                    else mPc = mPc + 4'd1;
                    mRet   = mRet + 8'd1;
                    mPhase = stopIn ? P_IDLE : P_FETCH;
                end
                default: mPhase = P_HALT;
            endcase
        end
    endtask

    task automatic compareAll();
        logic [3:0] op;
        logic       accReq, expWe;
        op     = mIr[7:4];
        accReq = (op >= 4'd1 && op <= 4'd5);
        expWe  = (mPhase == P_WB && op == 4'h6 && !rst);
        checkOutput("state", 32'(stateOut), 32'(mPhase));
        checkOutput("imemAddr", 32'(imemAddr), 32'(mPc));
        checkOutput("imm", 32'(imm), 32'(mIr[3:0]));
        checkOutput("retired", 32'(retired), 32'(mRet));
        checkOutput("accWe", 32'(accWe), 32'(mPhase == P_EXEC && accReq && !rst));
        checkOutput("aluOp", 32'(aluOp), (mPhase == P_EXEC && accReq && !rst) ? 32'(op) : 32'd0);
        checkOutput("writeEn", 32'(writeEn), 32'(expWe));
        checkOutput("writeAdd", 32'(writeAdd), expWe ? 32'(mIr[3:0]) : 32'd0);
        checkOutput("illegal", 32'(illegal), 32'(mPhase == P_DECODE && op >= 4'h9 && op <= 4'hE && !rst));
        checkOutput("halted", 32'(halted), 32'(mPhase == P_HALT));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        advanceModel();
        @(negedge clk);
        compareAll();
    endtask

    task automatic clearMem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [7:0] instr;
        logic       zero;
        logic [2:0] expAlu;
        logic       expAccWe;
        logic       expWe;
        logic       expIll;
        logic [3:0] expPc;
        logic       expHalt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{8'h15, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0};
        vecs[1] = '{8'h7A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0};
        vecs[2] = '{8'h84, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd1,  1'b0};
        vecs[3] = '{8'h84, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd4,  1'b0};
        vecs[4] = '{8'h90, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 4'd1,  1'b0};
        vecs[5] = '{8'h6C, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0};
        vecs[6] = '{8'h3B, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0};
        vecs[7] = '{8'h52, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0};
        vecs[8] = '{8'hF0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1};

        clearMem();

        // Reset held, then released with stop high: parked in IDLE.
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (5) stepCycle();
        checkOutput("idleState", 32'(stateOut), 32'd0);
        checkOutput("idlePc", 32'(imemAddr), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("leaveIdle", 32'(stateOut), 32'd1);

        // Straight-line program LDI 5; ADD 2; ST 3.
        clearMem();
        mem[0] = 8'h15; mem[1] = 8'h22; mem[2] = 8'h63;
        resetDut();
        for (int cyc = 1; cyc <= 13; cyc++) begin
            stepCycle();
            if (cyc == 3) begin
                checkOutput("progAccWe3", 32'(accWe), 32'd1);
                checkOutput("progAlu3", 32'(aluOp), 32'd1);
            end
            if (cyc == 7) begin
                checkOutput("progAccWe7", 32'(accWe), 32'd1);
                checkOutput("progAlu7", 32'(aluOp), 32'd2);
            end
            if (cyc == 12) begin
                checkOutput("progWe12", 32'(writeEn), 32'd1);
                checkOutput("progAdd12", 32'(writeAdd), 32'd3);
            end
        end
        checkOutput("progRetired", 32'(retired), 32'd3);
        checkOutput("progPc", 32'(imemAddr), 32'd3);

        // Single-instruction table at address 0.
        for (int v = 0; v < 9; v++) begin
            logic [2:0] sawAlu;
            logic       sawAcc, sawWe;
            int         illCount;
            sawAlu = 3'd0; sawAcc = 1'b0; sawWe = 1'b0; illCount = 0;
            clearMem();
            mem[0] = vecs[v].instr;
            resetDut();
            applyStimulus(1'b0, 1'b0, vecs[v].zero);
            for (int c = 0; c < 5; c++) begin
                stepCycle();
                if (accWe) begin sawAcc = 1'b1; sawAlu = aluOp; end
                if (writeEn) sawWe = 1'b1;
                if (illegal) illCount++;
            end
            checkOutput($sformatf("vec%0d.alu", v), 32'(sawAlu), 32'(vecs[v].expAlu));
            checkOutput($sformatf("vec%0d.accWe", v), 32'(sawAcc), 32'(vecs[v].expAccWe));
            checkOutput($sformatf("vec%0d.we", v), 32'(sawWe), 32'(vecs[v].expWe));
            checkOutput($sformatf("vec%0d.ill", v), 32'(illCount), 32'(vecs[v].expIll));
            checkOutput($sformatf("vec%0d.pc", v), 32'(imemAddr), 32'(vecs[v].expPc));
            checkOutput($sformatf("vec%0d.halt", v), 32'(halted), 32'(vecs[v].expHalt));
        end

        // JMP at address 15 takes its target; NOP at 15 wraps to 0.
        clearMem();
        mem[0] = 8'h7F; mem[15] = 8'h75;
        resetDut();
        repeat (9) stepCycle();
        checkOutput("jmpAt15", 32'(imemAddr), 32'd5);
        mem[15] = 8'h00;
        resetDut();
        repeat (9) stepCycle();
        checkOutput("wrapAt15", 32'(imemAddr), 32'd0);
        checkOutput("wrapRetired", 32'(retired), 32'd2);

        // HALT is sticky and ignores stop; only reset leaves it.
        clearMem();
        mem[0] = 8'hF0;
        resetDut();
        repeat (3) stepCycle();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, c[0], 1'b0);
            stepCycle();
            checkOutput("haltStays", 32'(stateOut), 32'd5);
            checkOutput("haltPc", 32'(imemAddr), 32'd0);
        end
        checkOutput("haltNoRetire", 32'(retired), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("haltExit", 32'(stateOut), 32'd0);
        checkOutput("haltExitFlag", 32'(halted), 32'd0);

        // Stop raised during EXECUTE of ST 7: write still happens, then IDLE.
        clearMem();
        mem[0] = 8'h67;
        resetDut();
        repeat (3) stepCycle();
        checkOutput("stopInExec", 32'(stateOut), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("stopWe", 32'(writeEn), 32'd1);
        checkOutput("stopAdd", 32'(writeAdd), 32'd7);
        stepCycle();
        checkOutput("stopIdle", 32'(stateOut), 32'd0);
        repeat (2) stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("resumeFetch", 32'(stateOut), 32'd1);
        checkOutput("resumePc", 32'(imemAddr), 32'd1);

        // Reset arriving in WRITEBACK of ST suppresses the strobe.
        clearMem();
        mem[0] = 8'h00; mem[1] = 8'h63;
        resetDut();
        repeat (8) stepCycle();
        checkOutput("wbBefore", 32'(stateOut), 32'd4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("wbResetStrobe", 32'(writeEn), 32'd0);
        stepCycle();
        checkOutput("wbResetPc", 32'(imemAddr), 32'd0);
        checkOutput("wbResetRetired", 32'(retired), 32'd0);

        // Random programs with random stop, zero and occasional reset.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] opR;
            opR = 4'($urandom_range(0, 14));
            mem[i] = {opR, 4'($urandom)};
        end
        resetDut();
        for (int c = 0; c < 800; c++) begin
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, 1'($urandom));
            stepCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
